ame_wr_dma: RTL and testbench
=============================

// Module: ame_wr_dma
// PURPOSE
// - AXI4 write-DMA stage feeding the AME master port. Takes the motion-estimation result word stream (valid/ready)
//   and writes it to memory as INCR bursts starting at a programmed base address, then pulses done.
// - Owns m_axi_aw*/w*/b*; the core only supplies base address, word count, start and the result stream.
// PARAMETERS
// - MAX_BURST  16  max beats per burst; power of 2, 1..256
// - LEN_W      16  width of word_cnt (max transfer 2^LEN_W-1 words)
// PORTS
// - m_axi_aclk     in   1      sole clock
// - m_axi_aresetn  in   1      async active-low reset
// - start          in   1      1-cycle request; sampled only in IDLE
// - base_addr      in   32     byte address; bits [1:0] forced to 0
// - word_cnt       in   LEN_W  number of 32-bit words to write
// - s_data         in   32     result word
// - s_valid        in   1      s_data valid
// - s_ready        out  1      word accepted when s_valid&s_ready
// - m_axi_awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid out, awready in   AXI4 AW channel
// - m_axi_wdata/wstrb/wlast/wvalid out, wready in                                          AXI4 W channel
// - m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1                                AXI4 B channel
// - busy           out  1      high from accepted start until done
// - done           out  1      1-cycle pulse at transfer end
// - error          out  1      sticky error flag, cleared by next accepted start
// BEHAVIOUR
// - Reset: all valids, bready, s_ready, busy, done, error = 0; awaddr=0, awlen=0; FSM=IDLE. Reset mid-transfer aborts at once.
// - Constants: awsize=3'b010, awburst=2'b01, awlock=0, awcache=4'b0011, awprot=0, awqos=0, wstrb=4'hF.
// - FSM: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
// - IDLE: start&word_cnt!=0 -> latch addr/remaining, busy=1, go AW. start&word_cnt==0 -> DONE (no AXI traffic).
//   start while busy is ignored.
// - AW: beats = min(remaining, MAX_BURST, (4096-addr[11:0])/4); never crosses a 4 KB page.
//   awaddr/awlen=beats-1 registered on entry; awvalid held until awready; no field changes while awvalid=1.
// - W: m_axi_wvalid=s_valid, s_ready=m_axi_wready, wdata=s_data (combinational pass, zero latency).
//   Beat counter increments per wvalid&wready; wlast=1 exactly on beat index beats-1. After last beat -> B.
// - B: bready=1; on bvalid: addr+=beats*4, remaining-=beats; remaining==0 -> DONE else AW.
//   One burst outstanding at a time; AW of next burst only after B of previous.
// - DONE: done=1 for exactly one cycle, busy falls same cycle, -> IDLE; start accepted again next cycle.
// - Address arithmetic 32-bit wraps modulo 2^32; caller guarantees buffer does not wrap.
// - s_valid/s_data ignored outside W state (s_ready=0).
// CONFIGURATION
// - AME_WR_DMA_BRESP_CHECK_EN defined: bresp!=2'b00 (SLVERR/DECERR) sets error; transfer still runs to completion and
//   done pulses normally. error clears on next accepted start.
// - Undefined: bresp ignored; error tied 0.
// TESTING
// - base=0x1000_0000, cnt=16, MAX_BURST=16 -> one AW awaddr=0x1000_0000 awlen=15; 16 W beats, wlast on 16th; done 1 cycle after B.
// - base=0x2000_0000, cnt=40 -> AWs at 0x2000_0000/0x2000_0040/0x2000_0080 with awlen 15/15/7; data order preserved.
// - base=0x0000_0FF0, cnt=8 -> AW 0x0FF0 awlen=3, then AW 0x1000 awlen=3 (4 KB split).
// - cnt=0 -> done pulse, busy 1 cycle, no awvalid/wvalid ever asserted.
// - cnt=32, bresp=2'b10 on burst 1 -> error=1 (macro on) / 0 (off); both bursts complete, done pulses.
// - random s_valid/wready/awready/bvalid stalls, reset asserted mid-W -> all outputs at reset values; next start cnt=4 completes.

Source files
------------

// File: rtl/ame_wr_dma.sv
// ame_wr_dma: AXI4 write DMA that bursts a valid/ready result-word stream to memory as 4 KB-safe INCR bursts.
// Optional feature: define AME_WR_DMA_BRESP_CHECK_EN to flag SLVERR/DECERR write responses on the sticky error output.
module ame_wr_dma #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic             m_axi_aclk,
  input  logic             m_axi_aresetn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] word_cnt,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      m_axi_awaddr,
  output logic [7:0]       m_axi_awlen,
  output logic [2:0]       m_axi_awsize,
  output logic [1:0]       m_axi_awburst,
  output logic             m_axi_awlock,
  output logic [3:0]       m_axi_awcache,
  output logic [2:0]       m_axi_awprot,
  output logic [3:0]       m_axi_awqos,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wlast,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [31:0]      addr_r;
  logic [7:0]       awlen_r;
  logic [LEN_W-1:0] rem_r;
  logic [BW-1:0]    beats_r;
  logic [BW-1:0]    beat_r;
  logic             awvalid_r;
  logic             bready_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;

  logic [31:0]      start_addr_s;
  logic [BW-1:0]    start_beats_s;
  logic [31:0]      next_addr_s;
  logic [LEN_W-1:0] next_rem_s;
  logic [BW-1:0]    next_beats_s;
  logic             w_hs_s;
  logic             last_beat_s;
  logic             bad_resp_s;
  logic             unused_s;

  // Burst size limited by words left, MAX_BURST and the words remaining in the current 4 KB page.
  function automatic logic [BW-1:0] calc_beats(input logic [9:0] page_word, input logic [LEN_W-1:0] rem);
    logic [31:0] room;
    logic [31:0] b;
    room = 32'd1024 - {22'd0, page_word};
    if (32'(rem) < 32'(MAX_BURST)) begin
      b = 32'(rem);
    end else begin
      b = 32'(MAX_BURST);
    end
    b = (room < b) ? room : b;
    return b[BW-1:0];
  endfunction

  assign start_addr_s  = {base_addr[31:2], 2'b00};
  assign start_beats_s = calc_beats(start_addr_s[11:2], word_cnt);
  assign next_addr_s   = addr_r + 32'({beats_r, 2'b00});
  assign next_rem_s    = rem_r - LEN_W'(beats_r);
  assign next_beats_s  = calc_beats(next_addr_s[11:2], next_rem_s);

  assign w_hs_s      = (state_r == ST_W) && s_valid && m_axi_wready;
  assign last_beat_s = (beat_r == (beats_r - BW'(1)));

`ifdef AME_WR_DMA_BRESP_CHECK_EN
  assign bad_resp_s = (m_axi_bresp != 2'b00);
  assign unused_s   = ^base_addr[1:0];
`else
  assign bad_resp_s = 1'b0;
  assign unused_s   = ^{base_addr[1:0], m_axi_bresp};
`endif

  // W channel is a zero-latency pass-through of the result stream while a burst is open.
  assign m_axi_wvalid = (state_r == ST_W) && s_valid;
  assign s_ready      = (state_r == ST_W) && m_axi_wready;
  assign m_axi_wdata  = s_data;
  assign m_axi_wlast  = (state_r == ST_W) && last_beat_s;
  assign m_axi_wstrb  = 4'hF;

  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = awlen_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_bready  = bready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

  // Transfer sequencer: one burst in flight, AW fields registered on entry and frozen while awvalid is high.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_r   <= ST_IDLE;
      addr_r    <= 32'd0;
      awlen_r   <= 8'd0;
      rem_r     <= {LEN_W{1'b0}};
      beats_r   <= {BW{1'b0}};
      beat_r    <= {BW{1'b0}};
      awvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r  <= 1'b1;
            error_r <= 1'b0;
            if (word_cnt != {LEN_W{1'b0}}) begin
              addr_r    <= start_addr_s;
              rem_r     <= word_cnt;
              beats_r   <= start_beats_s;
              awlen_r   <= 8'(start_beats_s - BW'(1));
              awvalid_r <= 1'b1;
              state_r   <= ST_AW;
            end else begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            awvalid_r <= 1'b0;
            beat_r    <= {BW{1'b0}};
            state_r   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs_s) begin
            if (last_beat_s) begin
              beat_r   <= {BW{1'b0}};
              bready_r <= 1'b1;
              state_r  <= ST_B;
            end else begin
              beat_r <= beat_r + BW'(1);
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            bready_r <= 1'b0;
            addr_r   <= next_addr_s;
            rem_r    <= next_rem_s;
            if (bad_resp_s) begin
              error_r <= 1'b1;
            end
            if (next_rem_s == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;
            end else begin
              beats_r   <= next_beats_s;
              awlen_r   <= 8'(next_beats_s - BW'(1));
              awvalid_r <= 1'b1;
              state_r   <= ST_AW;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ame_wr_dma.sv
// Randomized bench for ame_wr_dma: a transaction-level model (burst plan queue, word order, done/busy/error timing)
// is checked against the DUT every cycle, plus literal expectations for the directed address splits.
`timescale 1ns/1ps
module tb_ame_wr_dma;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [LEN_W-1:0] word_cnt = '0;
  logic [31:0] s_data = 32'd0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic awvalid;
  logic awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid;
  logic wready = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic bvalid = 1'b0;
  logic bready, busy, done, error;

  always #5 clk = ~clk;

  ame_wr_dma #(.MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  int vectors = 0;
  int miscompares = 0;
  burst_t exp_q[$];
  burst_t aw_log[$];
  burst_t cur;
  int words_seen = 0;
  int src_idx = 0;
  int rdy_pct = 100;
  int bad_burst = -1;
  int b_idx = 0;
  bit b_pend = 1'b0;
  bit b_done = 1'b0;
  bit aw_open, w_open, b_open, busy_m, done_m, done_p, err_m, fin, start_acc;
  bit aw_hs, w_hs, b_hs;
  int beat_m;
  logic [7:0] cur_len;

  function automatic logic [31:0] word_of(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst plan straight from the rules: min(words left, MAX_BURST, words to page end).
  function automatic void plan(input logic [31:0] base, input int cnt);
    logic [31:0] a;
    int rem, room, b;
    burst_t e;
    a = base & 32'hFFFF_FFFC;
    rem = cnt;
    while (rem > 0) begin
      room = (4096 - int'(a & 32'h0000_0FFF)) / 4;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      e.addr = a;
      e.len = 8'(b - 1);
      exp_q.push_back(e);
      a = a + 32'(4 * b);
      rem -= b;
    end
  endfunction

  // Slave and source driver: random stalls on every ready/valid, one B response per completed burst.
  always @(negedge clk) begin
    if (!rst_n) begin
      bvalid = 1'b0;
      b_pend = 1'b0;
      b_done = 1'b0;
      s_valid = 1'b0;
    end else begin
      if (b_done) begin
        bvalid = 1'b0;
        b_pend = 1'b0;
        b_done = 1'b0;
        b_idx++;
      end
      awready = ($urandom_range(0, 99) < rdy_pct);
      wready  = ($urandom_range(0, 99) < rdy_pct);
      s_valid = ($urandom_range(0, 99) < rdy_pct);
      s_data  = s_valid ? word_of(src_idx) : $urandom();
      if (!bvalid && b_pend && ($urandom_range(0, 99) < rdy_pct)) begin
        bvalid = 1'b1;
        bresp  = (b_idx == bad_burst) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11) : 2'b00;
      end else if (!bvalid) begin
        bresp = 2'($urandom_range(0, 3));
      end
      #1;
      if (s_valid && s_ready) src_idx++;
      if (wvalid && wready && wlast) b_pend = 1'b1;
      if (bvalid && bready) b_done = 1'b1;
    end
  end

  // Compare process: checks every output against the model, then steps the model by the observed handshakes.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      {aw_open, w_open, b_open, busy_m, done_m, done_p, err_m} = 7'd0;
      beat_m = 0;
      check("rst_ctrl", {25'd0, awvalid, wvalid, s_ready, bready, busy, done, error}, 32'd0);
      check("rst_awaddr", awaddr, 32'd0);
      check("rst_awlen", {24'd0, awlen}, 32'd0);
    end else begin
      check("awvalid", {31'd0, awvalid}, {31'd0, aw_open});
      if (aw_open && exp_q.size() > 0) begin
        check("awaddr", awaddr, exp_q[0].addr);
        check("awlen", {24'd0, awlen}, {24'd0, exp_q[0].len});
        check("aw_const", {11'd0, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
              {11'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'hF});
      end
      check("wvalid", {31'd0, wvalid}, {31'd0, w_open & s_valid});
      check("s_ready", {31'd0, s_ready}, {31'd0, w_open & wready});
      check("bready", {31'd0, bready}, {31'd0, b_open});
      check("busy", {31'd0, busy}, {31'd0, busy_m});
      check("done", {31'd0, done}, {31'd0, done_m});
      check("error", {31'd0, error}, {31'd0, err_m});
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (w_hs) begin
        check("wdata", wdata, word_of(words_seen));
        check("wlast", {31'd0, wlast}, {31'd0, (8'(beat_m) == cur_len)});
        words_seen++;
      end
      start_acc = start && !busy_m;
      fin = 1'b0;
      done_m = done_p;
      if (done_m) busy_m = 1'b0;
      if (start_acc) begin
        err_m = 1'b0;
        busy_m = 1'b1;
        if (word_cnt == '0) fin = 1'b1;
        else begin
          plan(base_addr, int'(word_cnt));
          aw_open = 1'b1;
        end
      end
      if (aw_hs && aw_open && exp_q.size() > 0) begin
        cur.addr = awaddr;
        cur.len = awlen;
        aw_log.push_back(cur);
        cur_len = exp_q[0].len;
        void'(exp_q.pop_front());
        aw_open = 1'b0;
        w_open = 1'b1;
        beat_m = 0;
      end else if (w_hs && w_open) begin
        if (8'(beat_m) == cur_len) begin
          w_open = 1'b0;
          b_open = 1'b1;
        end else begin
          beat_m++;
        end
      end else if (b_hs && b_open) begin
        b_open = 1'b0;
`ifdef AME_WR_DMA_BRESP_CHECK_EN
        if (bresp != 2'b00) err_m = 1'b1;
`endif
        if (exp_q.size() > 0) aw_open = 1'b1;
        else fin = 1'b1;
      end
      done_p = fin;
    end
  end

  task automatic run(input logic [31:0] base, input int cnt, input int pct, input int badb, input int poke);
    bit got;
    int w0;
    rdy_pct = pct;
    bad_burst = badb;
    b_idx = 0;
    aw_log.delete();
    w0 = words_seen;
    @(negedge clk);
    base_addr = base;
    word_cnt = LEN_W'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom();
    word_cnt = LEN_W'($urandom());
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (poke > 0 && i == poke) begin
        word_cnt = LEN_W'(3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #3;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout: no done within 4000 cycles for base %h cnt %0d", base, cnt);
    end
    check("word_count", 32'(words_seen - w0), 32'(cnt));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit reached;
    int w0;
    logic [31:0] rb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h1000_0000, 16, 100, -1, 0);
    check("t1_naw", 32'(aw_log.size()), 32'd1);
    if (aw_log.size() == 1) begin
      check("t1_addr", aw_log[0].addr, 32'h1000_0000);
      check("t1_len", {24'd0, aw_log[0].len}, 32'd15);
    end

    run(32'h2000_0000, 40, 60, -1, 0);
    check("t2_naw", 32'(aw_log.size()), 32'd3);
    if (aw_log.size() == 3) begin
      check("t2_addr1", aw_log[1].addr, 32'h2000_0040);
      check("t2_addr2", aw_log[2].addr, 32'h2000_0080);
      check("t2_len0", {24'd0, aw_log[0].len}, 32'd15);
      check("t2_len2", {24'd0, aw_log[2].len}, 32'd7);
    end

    run(32'h0000_0FF0, 8, 70, -1, 0);
    check("t3_naw", 32'(aw_log.size()), 32'd2);
    if (aw_log.size() == 2) begin
      check("t3_addr0", aw_log[0].addr, 32'h0000_0FF0);
      check("t3_len0", {24'd0, aw_log[0].len}, 32'd3);
      check("t3_addr1", aw_log[1].addr, 32'h0000_1000);
      check("t3_len1", {24'd0, aw_log[1].len}, 32'd3);
    end

    run(32'h5000_0000, 0, 100, -1, 0);
    check("t4_naw", 32'(aw_log.size()), 32'd0);

    run(32'h4000_0000, 32, 80, 0, 10);
    check("t5_naw", 32'(aw_log.size()), 32'd2);
`ifdef AME_WR_DMA_BRESP_CHECK_EN
    check("t5_error", {31'd0, error}, 32'd1);
`else
    check("t5_error", {31'd0, error}, 32'd0);
`endif

    run(32'h3000_0FFB, 5, 90, -1, 0);
    check("t6_naw", 32'(aw_log.size()), 32'd2);
    if (aw_log.size() == 2) begin
      check("t6_addr0", aw_log[0].addr, 32'h3000_0FF8);
      check("t6_len0", {24'd0, aw_log[0].len}, 32'd1);
      check("t6_len1", {24'd0, aw_log[1].len}, 32'd2);
    end

    for (int k = 0; k < 8; k++) begin
      rb = $urandom();
      if ($urandom_range(0, 1) == 1) rb[11:6] = 6'h3F;
      run(rb, $urandom_range(1, 70), $urandom_range(25, 100), $urandom_range(0, 4) - 1, 0);
    end

    // Reset in the middle of a data burst, then a short transfer must still complete.
    rdy_pct = 70;
    bad_burst = -1;
    w0 = words_seen;
    @(negedge clk);
    base_addr = 32'h6000_0000;
    word_cnt = LEN_W'(40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #3;
      if (w_open && (words_seen - w0) >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      miscompares++;
      $display("FAIL reach_w: transfer did not reach data phase within 500 cycles");
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(32'h7000_0100, 4, 60, -1, 0);
    check("t7_naw", 32'(aw_log.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
